// File: rtl/spi_cs_arbiter.sv
// Round-robin owner of one SPI host datapath: sequences the owner's chip select
// through setup, active and hold phases, then enforces an idle gap before re-arbitrating.
module spi_cs_arbiter #(
    parameter int NumReq = 4,
    parameter int CntW   = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumReq-1:0] req_i,
    input  logic [NumReq-1:0] release_i,
    input  logic              spi_busy_i,
    input  logic [CntW-1:0]   setup_cycles_i,
    input  logic [CntW-1:0]   hold_cycles_i,
    input  logic [CntW-1:0]   gap_cycles_i,
    output logic [NumReq-1:0] grant_o,
    output logic [NumReq-1:0] cs_no,
    output logic              bus_ready_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACTIVE,
        ST_HOLD,
        ST_GAP
    } state_t;

    state_t          state_reg, state_next;
    logic [CntW-1:0] cnt_reg, cnt_next;
    logic [IdxW-1:0] owner_reg, owner_next;
    logic [IdxW-1:0] last_reg, last_next;
    logic [IdxW-1:0] pick_idx;
    logic            pick_found;
    logic            cnt_zero;
    logic            owner_done;
    logic            owned;

    // First requester found walking upward from the one after the previous owner.
    always_comb begin
        pick_idx   = last_reg;
        pick_found = 1'b0;
        for (int i = 1; i <= NumReq; i++) begin
            if (!pick_found && req_i[(int'(last_reg) + i) % NumReq]) begin
                pick_found = 1'b1;
                pick_idx   = IdxW'((int'(last_reg) + i) % NumReq);
            end
        end
    end

    assign cnt_zero   = (cnt_reg == '0);
    // A release pulse during a busy shift is dropped; req_i must still be high or the
    // owner must drop req_i to end the transaction once the shifter is idle.
    assign owner_done = (release_i[owner_reg] | ~req_i[owner_reg]) & ~spi_busy_i;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        last_next  = last_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (pick_found) begin
                    owner_next = pick_idx;
                    cnt_next   = setup_cycles_i;
                    state_next = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_next = ST_ACTIVE;
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            ST_ACTIVE: begin
                if (owner_done) begin
                    cnt_next   = hold_cycles_i;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    last_next  = owner_reg;
                    cnt_next   = gap_cycles_i;
                    state_next = ST_GAP;
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_zero) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CntW'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            owner_reg <= '0;
            last_reg  <= IdxW'(NumReq - 1);
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
            last_reg  <= last_next;
        end
    end

    // Outputs are a pure decode of registered state so no input reaches a pin combinationally.
    assign owned       = (state_reg == ST_SETUP) || (state_reg == ST_ACTIVE) ||
                         (state_reg == ST_HOLD);
    assign bus_ready_o = (state_reg == ST_ACTIVE);

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_cs
        assign grant_o[gi] = owned && (owner_reg == IdxW'(gi));
        assign cs_no[gi]   = ~grant_o[gi];
    end

endmodule

// File: tb/tb_spi_cs_arbiter.sv
// Bench for spi_cs_arbiter: directed scenarios with literal expectations plus a random run,
// all checked every cycle against a timestamp-based model of the CS/ready schedule.
module tb_spi_cs_arbiter;

    localparam int NR   = 4;
    localparam int CntW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR-1:0]   rel = '0;
    logic            busy = 1'b0;
    logic [CntW-1:0] setup_c = '0;
    logic [CntW-1:0] hold_c = '0;
    logic [CntW-1:0] gap_c = '0;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   cs_n;
    logic            ready;

    spi_cs_arbiter #(.NumReq(NR), .CntW(CntW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .release_i      (rel),
        .spi_busy_i     (busy),
        .setup_cycles_i (setup_c),
        .hold_cycles_i  (hold_c),
        .gap_cycles_i   (gap_c),
        .grant_o        (grant),
        .cs_no          (cs_n),
        .bus_ready_o    (ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n   = 0;

    // Model: absolute cycle stamps of one transaction. Cycle c ends at edge c.
    bit            m_txn, m_rel, m_gap_known;
    int            m_owner, m_last;
    int            m_start, m_ready_first, m_cs_last, m_idle_first;
    logic [NR-1:0] exp_grant = '0;
    logic [NR-1:0] exp_cs = '1;
    logic          exp_ready = 1'b0;

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, edge_n);
        end
    endfunction

    function automatic void timeout(string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting (cycle %0d)", name, edge_n);
    endfunction

    function automatic bit m_idle(int c);
        return !m_txn || (m_gap_known && c >= m_idle_first);
    endfunction

    function automatic void model_reset();
        m_txn       = 1'b0;
        m_rel       = 1'b0;
        m_gap_known = 1'b0;
        m_owner     = 0;
        m_last      = NR - 1;
        exp_grant   = '0;
        exp_cs      = '1;
        exp_ready   = 1'b0;
    endfunction

    function automatic void model_step(int e);
        bit found;
        int c;
        if (m_idle(e)) begin
            if (req != '0) begin
                found = 1'b0;
                for (int i = 1; i <= NR; i++) begin
                    if (!found && req[(m_last + i) % NR]) begin
                        found   = 1'b1;
                        m_owner = (m_last + i) % NR;
                    end
                end
                m_txn         = 1'b1;
                m_rel         = 1'b0;
                m_gap_known   = 1'b0;
                m_start       = e + 1;
                m_ready_first = e + 2 + int'(setup_c);
                $display("txn: requester %0d granted at cycle %0d, setup %0d", m_owner, e + 1, setup_c);
            end
        end else if (!m_rel && e >= m_ready_first) begin
            if ((rel[m_owner] || !req[m_owner]) && !busy) begin
                m_rel     = 1'b1;
                m_cs_last = e + 1 + int'(hold_c);
                m_last    = m_owner;
            end
        end else if (m_rel && !m_gap_known && e == m_cs_last) begin
            m_gap_known  = 1'b1;
            m_idle_first = e + 2 + int'(gap_c);
        end
        c         = e + 1;
        exp_grant = '0;
        if (m_txn && c >= m_start && (!m_rel || c <= m_cs_last)) exp_grant[m_owner] = 1'b1;
        exp_cs    = ~exp_grant;
        exp_ready = m_txn && !m_rel && c >= m_ready_first;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(edge_n);
        edge_n++;
        #1;
    endtask

    always @(negedge clk) begin
        check("grant", int'(grant), int'(exp_grant));
        check("cs_n", int'(cs_n), int'(exp_cs));
        check("ready", int'(ready), int'(exp_ready));
        check("inv_grant_onehot0", int'($onehot0(grant)), 1);
        check("inv_cs_single_low", int'($onehot0(~cs_n)), 1);
        check("inv_ready_needs_grant", int'(!ready || (grant != '0)), 1);
        check("inv_cs_matches_grant", int'((~cs_n) == grant), 1);
    end

    function automatic int idx_of(logic [NR-1:0] g);
        for (int k = 0; k < NR; k++) if (g[k]) return k;
        return -1;
    endfunction

    task automatic wait_ready(string name);
        for (int n = 0; n < 600; n++) begin
            if (ready) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic wait_grant(string name, bit want);
        for (int n = 0; n < 600; n++) begin
            if ((grant != '0) == want) return;
            tick();
        end
        timeout(name);
    endtask

    task automatic drain();
        req  = '0;
        rel  = '0;
        busy = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (m_idle(edge_n)) return;
            tick();
        end
        timeout("drain");
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic measure_setup(output int n);
        n = 0;
        for (int k = 0; k < 600; k++) begin
            if (grant == '0 || ready) return;
            n++;
            tick();
        end
        timeout("measure_setup");
    endtask

    int order[$];
    int exp_order[5];
    int n_setup;
    int act_cnt;
    logic [NR-1:0] prev_g;

    initial begin
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        check("reset_grant", int'(grant), 0);
        check("reset_cs", int'(cs_n), 15);
        check("reset_ready", int'(ready), 0);

        // Single requester timing: setup=2 hold=1 gap=3, release at edge 10.
        setup_c = 8'd2; hold_c = 8'd1; gap_c = 8'd3;
        for (int i = 0; i <= 18; i++) begin
            req = (i <= 10 || i >= 12) ? 4'b0001 : 4'b0000;
            rel = (i == 10) ? 4'b0001 : 4'b0000;
            tick();
            check($sformatf("t1_cs0_c%0d", i + 1), int'(cs_n[0]), (i + 1 <= 12 || i + 1 >= 18) ? 0 : 1);
            check($sformatf("t1_ready_c%0d", i + 1), int'(ready), (i + 1 >= 4 && i + 1 <= 10) ? 1 : 0);
        end
        drain();

        // Round robin with all phases zero and every requester asking.
        apply_reset();
        setup_c = '0; hold_c = '0; gap_c = '0;
        req = 4'b1111;
        act_cnt = 0;
        prev_g = '0;
        order.delete();
        for (int i = 0; i < 200 && order.size() < 5; i++) begin
            tick();
            rel = '0;
            if (grant != '0 && prev_g == '0) order.push_back(idx_of(grant));
            prev_g = grant;
            if (ready) begin
                act_cnt++;
                if (act_cnt == 2) begin
                    rel = grant;
                    act_cnt = 0;
                end
            end else begin
                act_cnt = 0;
            end
        end
        rel = '0;
        exp_order = '{0, 1, 2, 3, 0};
        check("rr_count", order.size(), 5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            check($sformatf("rr_order_%0d", k), order[k], exp_order[k]);
        drain();

        // Release during busy is not remembered.
        setup_c = 8'd1; hold_c = 8'd2; gap_c = 8'd1;
        req = 4'b0010;
        wait_ready("busy_wait_ready");
        busy = 1'b1;
        rel = 4'b0010;
        tick();
        rel = '0;
        tick();
        check("busy_stays_ready", int'(ready), 1);
        check("busy_owner", int'(grant), 2);
        busy = 1'b0;
        repeat (2) tick();
        check("busy_no_memory", int'(ready), 1);
        rel = 4'b0010;
        tick();
        rel = '0;
        check("busy_hold_ready", int'(ready), 0);
        check("busy_hold_cs", int'(cs_n), 13);
        drain();

        // Owner 2 drops its request in ACTIVE.
        setup_c = 8'd0; hold_c = 8'd1; gap_c = 8'd0;
        req = 4'b0100;
        wait_ready("drop_wait_ready");
        req = '0;
        tick();
        check("drop_hold_ready", int'(ready), 0);
        check("drop_hold_cs_a", int'(cs_n), 11);
        tick();
        check("drop_hold_cs_b", int'(cs_n), 11);
        tick();
        check("drop_cs_high", int'(cs_n), 15);
        drain();

        // Asynchronous reset in the middle of owner 1's ACTIVE phase.
        req = 4'b0010;
        wait_ready("rst_wait_ready");
        check("rst_owner1", int'(grant), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_cs", int'(cs_n), 15);
        check("rst_async_grant", int'(grant), 0);
        check("rst_async_ready", int'(ready), 0);
        req = 4'b0011;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_grant("rst_wait_grant", 1'b1);
        check("rst_priority_0", int'(grant), 1);
        drain();

        // Setup change mid-SETUP only affects the next load.
        setup_c = 8'd5; hold_c = 8'd0; gap_c = 8'd0;
        req = 4'b0001;
        wait_grant("cfg_wait_grant", 1'b1);
        setup_c = 8'd0;
        measure_setup(n_setup);
        check("cfg_setup_old", n_setup, 6);
        rel = 4'b0001;
        tick();
        rel = '0;
        wait_grant("cfg_wait_gap", 1'b0);
        wait_grant("cfg_wait_grant2", 1'b1);
        measure_setup(n_setup);
        check("cfg_setup_new", n_setup, 1);
        drain();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < NR; b++) if ($urandom_range(7) == 0) req[b] = ~req[b];
            for (int b = 0; b < NR; b++) rel[b] = ($urandom_range(5) == 0);
            busy = ($urandom_range(2) == 0);
            if ($urandom_range(40) == 0) begin
                setup_c = CntW'($urandom_range(($urandom_range(9) == 0) ? 20 : 3));
                hold_c  = CntW'($urandom_range(($urandom_range(9) == 0) ? 20 : 3));
                gap_c   = CntW'($urandom_range(($urandom_range(9) == 0) ? 20 : 3));
            end
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                model_reset();
                #1;
                check("rand_reset_cs", int'(cs_n), 15);
            end
            tick();
            if (i == 1500) rst_n = 1'b1;
        end
        drain();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_cs_arbiter.md
# spi_cs_arbiter

Shares one SPI host datapath between `NumReq` requesters, each owning one active-low chip select. It arbitrates round-robin, sequences CS setup, active and hold phases with programmable cycle counts, and enforces an inter-transaction gap. It sits between the SPI host register/shift block and the chip-select pins of one SPI instance. Its outputs are the only CS drivers for that instance.

## Interface
Parameters:
- `NumReq`, default 4: number of requesters and chip selects, equal to the system SPI chip-select count. Legal range 1..16.
- `CntW`, default 8: width of the phase-length configuration inputs and of the internal counter.

Ports:
- `clk_i`  in  1: single clock domain.
- `rst_ni`  in  1: reset, asynchronous, active-low.
- `req_i`  in  NumReq: level request per requester. A requester holds it until its transaction ends.
- `release_i`  in  NumReq: one-cycle end-of-transaction pulse per requester.
- `spi_busy_i`  in  1: SPI host still shifting.
- `setup_cycles_i`  in  CntW: CS-low to bus-ready delay minus 1.
- `hold_cycles_i`  in  CntW: last-bit to CS-high delay minus 1.
- `gap_cycles_i`  in  CntW: CS-high idle time minus 1.
- `grant_o`  out  NumReq: one-hot owner, or all zero when there is no owner.
- `cs_no`  out  NumReq: active-low chip selects, at most one low.
- `bus_ready_o`  out  1: owner may start or continue shifting.

## Operation
- FSM states are IDLE, SETUP, ACTIVE, HOLD and GAP. There is one down-counter `cnt` of width CntW. Registers hold `owner` (index) and `last` (round-robin pointer).
- All outputs decode from registered state and `owner` only. There is no combinational path from any input to any output.
- **IDLE:** `grant_o`=0, `cs_no`=all ones, `bus_ready_o`=0.
  - If `req_i`≠0, choose the first set bit searching from `last`+1 modulo NumReq.
  - Latch that index into `owner`, load `cnt`←`setup_cycles_i`, and move to SETUP.
- **SETUP:** `grant_o[owner]`=1, `cs_no[owner]`=0, `bus_ready_o`=0.
  - If `cnt`==0, move to ACTIVE. Otherwise decrement `cnt`.
  - SETUP therefore lasts `setup_cycles_i`+1 cycles.
- **ACTIVE:** as SETUP, but with `bus_ready_o`=1.
  - Exit condition: (`release_i[owner]` | ~`req_i[owner]`) & ~`spi_busy_i`.
  - On exit, load `cnt`←`hold_cycles_i` and move to HOLD.
  - A release seen while `spi_busy_i`=1 is not remembered. Requesters keep `req_i` high until their release is accepted, and dropping `req_i` alone ends the transaction once the bus is idle.
  - `release_i` bits of non-owners are ignored.
- **HOLD:** `grant_o[owner]`=1, `cs_no[owner]`=0, `bus_ready_o`=0.
  - Counts down like SETUP, lasting `hold_cycles_i`+1 cycles.
  - When done, set `last`←`owner`, load `cnt`←`gap_cycles_i`, and move to GAP.
- **GAP:** `grant_o`=0, `cs_no`=all ones, `bus_ready_o`=0.
  - Counts down for `gap_cycles_i`+1 cycles, then moves to IDLE.
- Configuration inputs are sampled only at counter load. Changes made mid-phase take effect at the next load.
- Requests arriving in any state other than IDLE wait. A requester is never pre-empted.
- With NumReq=1, the round-robin search is trivially index 0.

## Timing
- Reset values:
  - state=IDLE, `cnt`=0, `owner`=0.
  - `last`=NumReq-1, so requester 0 has first priority after reset.
  - `grant_o`=0, `cs_no`=all ones, `bus_ready_o`=0.
- Latency:
  - A request sampled in IDLE at edge t drives CS low and grant high from cycle t+1.
  - `bus_ready_o` rises at cycle t+2+`setup_cycles_i`.
- A release accepted at edge k causes:
  - `bus_ready_o` low at k+1,
  - CS high at k+2+`hold_cycles_i`,
  - IDLE at k+3+`hold_cycles_i`+`gap_cycles_i`.
  - The earliest next CS low is one cycle after IDLE is reached.
- Reset asserted in any state forces the reset values asynchronously. CS deasserts immediately, even mid-transfer.
- Invariants, each checked every cycle by assertions:
  - `grant_o` is onehot0.
  - `cs_no` has at most one zero.
  - `bus_ready_o` implies a grant.
  - ~`cs_no` equals `grant_o`.

## Test plan
- **Single requester timing:** setup=2, hold=1, gap=3. `req_i`=0001 at edge 0; release pulse at edge 10 with busy=0.
  - Required: CS0 low cycles 1–12, ready cycles 4–10, GAP cycles 13–16, IDLE at 17.
- **Round-robin:** all phase configs 0, `req_i`=1111 held.
  - Required: grant order 0,1,2,3,0. Each owner is released after 2 ACTIVE cycles.
- **Busy stretch:** release pulse while `spi_busy_i`=1, with `req_i` held.
  - Required: stays in ACTIVE. After busy falls and a second release arrives, HOLD follows on the next cycle.
- **Requester drop:** owner 2 deasserts `req_i` in ACTIVE with busy=0.
  - Required: HOLD next cycle, CS2 high after hold.
- **Reset mid-transfer:** `rst_ni` low during ACTIVE of owner 1.
  - Required: `cs_no`=1111 and `grant_o`=0 immediately. After reset, requester 0 wins over 1 when both request.
- **Config change:** change setup from 5 to 0 during SETUP.
  - Required: the current SETUP still lasts 6 cycles; the next SETUP lasts 1.
